// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller: FSM states,
// active-low 7-segment patterns (gfedcba) and active-low digit-select codes.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sw_state_e;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [1:0] DIG_SEL_UNITS = 2'b10;
    localparam logic [1:0] DIG_SEL_TENS  = 2'b01;

endpackage

// File: rtl/stopwatch_ctrl_seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes blank the digit.
module seg7_decode
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Two-digit stopwatch: button conditioning, IDLE/RUN/PAUSE FSM, BCD counter and
// muxed 7-segment scan. Define STOPWATCH_DEBOUNCE_EN to insert the debounce stage.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV  = 5000000,
    parameter int SCAN_DIV  = 50000,
    parameter int DB_CYCLES = 250000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       BTN_START,
    input  logic       BTN_CLEAR,
    output logic [3:0] CNTVAL_low,
    output logic [3:0] CNTVAL_high,
    output logic       OV,
    output logic [6:0] SEG,
    output logic [1:0] DIG_SEL,
    output logic       RUNNING
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);

    logic [1:0] btn_raw;
    logic [1:0] btn_pulse;
    logic       start_p;
    logic       clear_p;

    assign btn_raw = {BTN_CLEAR, BTN_START};
    assign start_p = btn_pulse[0];
    assign clear_p = btn_pulse[1];

    // Per button: 2-FF synchronizer, optional debounce, registered rising-edge pulse.
    for (genvar i = 0; i < 2; i++) begin : g_btn
        logic sync1_q, sync1_d, sync2_q, sync2_d;
        logic prev_q, prev_d, pulse_q, pulse_d;
        logic level;
`ifdef STOPWATCH_DEBOUNCE_EN
        localparam int DBW = $clog2(DB_CYCLES + 1);
        logic           db_q, db_d;
        logic [DBW-1:0] db_cnt_q, db_cnt_d;

        always_comb begin
            db_d     = db_q;
            db_cnt_d = '0;
            if (sync2_q != db_q) begin
                if (db_cnt_q == DBW'(DB_CYCLES - 1)) begin
                    db_d = sync2_q;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge CLK) begin
            if (!RST_N) begin
                db_q     <= 1'b0;
                db_cnt_q <= '0;
            end else begin
                db_q     <= db_d;
                db_cnt_q <= db_cnt_d;
            end
        end

        assign level = db_q;
`else
        assign level = sync2_q;
`endif

        always_comb begin
            sync1_d = btn_raw[i];
            sync2_d = sync1_q;
            prev_d  = level;
            pulse_d = level & ~prev_q;
        end

        always_ff @(posedge CLK) begin
            if (!RST_N) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                prev_q  <= 1'b0;
                pulse_q <= 1'b0;
            end else begin
                sync1_q <= sync1_d;
                sync2_q <= sync2_d;
                prev_q  <= prev_d;
                pulse_q <= pulse_d;
            end
        end

        assign btn_pulse[i] = pulse_q;
    end

    sw_state_e      state_q, state_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [3:0]     low_q, low_d, high_q, high_d;
    logic           ov_q, ov_d, running_q, running_d;
    logic           tick;

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        low_d   = low_q;
        high_d  = high_q;
        ov_d    = 1'b0;
        tick    = (state_q == ST_RUN) && (presc_q == PW'(TICK_DIV - 1));

        // Prescaler only advances in RUN, so PAUSE keeps the partial tick.
        if (state_q == ST_RUN) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end

        if (tick) begin
            if (low_q == 4'd9) begin
                low_d = 4'd0;
                if (high_q == 4'd9) begin
                    high_d = 4'd0;
                    ov_d   = 1'b1;
                end else begin
                    high_d = high_q + 4'd1;
                end
            end else begin
                low_d = low_q + 4'd1;
            end
        end

        if (start_p) begin
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end

        // Clear overrides both the start transition and any tick on this edge.
        if (clear_p) begin
            state_d = ST_IDLE;
            presc_d = '0;
            low_d   = 4'd0;
            high_d  = 4'd0;
            ov_d    = 1'b0;
        end

        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            low_q     <= 4'd0;
            high_q    <= 4'd0;
            ov_q      <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            low_q     <= low_d;
            high_q    <= high_d;
            ov_q      <= ov_d;
            running_q <= running_d;
        end
    end

    logic [SW-1:0] scan_q, scan_d;
    logic          slot_q, slot_d;
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    dig_sel_q, dig_sel_d;
    logic          scan_wrap;

    always_comb begin
        scan_wrap = (scan_q == SW'(SCAN_DIV - 1));
        scan_d    = scan_wrap ? '0 : scan_q + 1'b1;
        slot_d    = scan_wrap ? ~slot_q : slot_q;
        dig_sel_d = slot_d ? DIG_SEL_TENS : DIG_SEL_UNITS;
    end

    // Segment pattern and digit select come from the same slot_d and are
    // registered together, so the bus never shows one digit under the other's enable.
    seg7_decode u_decode (
        .bcd (slot_d ? high_q : low_q),
        .seg (seg_d)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            scan_q    <= '0;
            slot_q    <= 1'b0;
            seg_q     <= SEG_0;
            dig_sel_q <= DIG_SEL_UNITS;
        end else begin
            scan_q    <= scan_d;
            slot_q    <= slot_d;
            seg_q     <= seg_d;
            dig_sel_q <= dig_sel_d;
        end
    end

    assign CNTVAL_low  = low_q;
    assign CNTVAL_high = high_q;
    assign OV          = ov_q;
    assign RUNNING     = running_q;
    assign SEG         = seg_q;
    assign DIG_SEL     = dig_sel_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: a count-from-run-time reference model queues
// expected digit changes; a negedge monitor pops and compares them.
module tb_stopwatch_ctrl;

    localparam int TICK_DIV  = 4;
    localparam int SCAN_DIV  = 3;
    localparam int DB_CYCLES = 4;
`ifdef STOPWATCH_DEBOUNCE_EN
    localparam int LAT = 3 + DB_CYCLES;
`else
    localparam int LAT = 3;
`endif
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int EW      = 41;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       BTN_START = 1'b0;
    logic       BTN_CLEAR = 1'b0;
    logic [3:0] CNTVAL_low, CNTVAL_high;
    logic       OV, RUNNING;
    logic [6:0] SEG;
    logic [1:0] DIG_SEL;

    stopwatch_ctrl #(
        .TICK_DIV  (TICK_DIV),
        .SCAN_DIV  (SCAN_DIV),
        .DB_CYCLES (DB_CYCLES)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .BTN_START   (BTN_START),
        .BTN_CLEAR   (BTN_CLEAR),
        .CNTVAL_low  (CNTVAL_low),
        .CNTVAL_high (CNTVAL_high),
        .OV          (OV),
        .SEG         (SEG),
        .DIG_SEL     (DIG_SEL),
        .RUNNING     (RUNNING)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    logic [EW-1:0] exp_q[$];
    logic [6:0]    seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    // Reference model: displayed value = (cycles spent running since clear / TICK_DIV) mod 100.
    int cyc = 0;
    int scan_n = 0;
    int m_mode = M_IDLE;
    int m_run = 0;
    bit start_at[int];
    bit clear_at[int];

    function automatic int cnt_of(int r);
        return (r / TICK_DIV) % 100;
    endfunction

    function automatic int pmod(int x, int m);
        return ((x % m) + m) % m;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge CLK) begin
        int old_v, new_v;
        bit clr, st;
        cyc++;
        old_v = cnt_of(m_run);
        if (!RST_N) begin
            scan_n = 0;
            m_run  = 0;
            m_mode = M_IDLE;
            start_at.delete();
            clear_at.delete();
            if (old_v != 0) exp_q.push_back({32'(cyc), 4'd0, 4'd0, 1'b0});
        end else begin
            scan_n++;
            clr = clear_at.exists(cyc);
            st  = start_at.exists(cyc);
            if (clr) begin
                m_run  = 0;
                m_mode = M_IDLE;
            end else begin
                if (m_mode == M_RUN) m_run++;
                if (st) m_mode = (m_mode == M_RUN) ? M_PAUSE : M_RUN;
            end
            new_v = cnt_of(m_run);
            if (new_v != old_v)
                exp_q.push_back({32'(cyc), 4'(new_v / 10), 4'(new_v % 10), (!clr && new_v == 0)});
        end
    end

    // Monitor: digit changes are popped against the queue; RUNNING and the scan bus every cycle.
    logic [3:0]    prev_low = 4'd0, prev_high = 4'd0;
    logic [EW-1:0] mon_e;

    always @(negedge CLK) begin
        int slot;
        if (cyc > 0) begin
            check("running", 32'(RUNNING), 32'(m_mode == M_RUN));
            if ({CNTVAL_high, CNTVAL_low} !== {prev_high, prev_low}) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_count_change", {24'd0, CNTVAL_high, CNTVAL_low}, {24'd0, prev_high, prev_low});
                end else begin
                    mon_e = exp_q.pop_front();
                    check("change_cycle", 32'(cyc), mon_e[40:9]);
                    check("digits", {24'd0, CNTVAL_high, CNTVAL_low}, {24'd0, mon_e[8:5], mon_e[4:1]});
                    check("ov_on_change", 32'(OV), 32'(mon_e[0]));
                end
            end else begin
                check("ov_idle", 32'(OV), 32'd0);
            end
            slot = (scan_n / SCAN_DIV) % 2;
            check("dig_sel", 32'(DIG_SEL), (slot == 1) ? 32'd1 : 32'd2);
            if (scan_n == 0) check("seg_reset", 32'(SEG), 32'(seg_tab[0]));
            else check("seg", 32'(SEG), 32'(seg_tab[(slot == 1) ? prev_high : prev_low]));
            prev_low  = CNTVAL_low;
            prev_high = CNTVAL_high;
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic press(bit do_start, bit do_clear, int hold, int gap);
        if (do_start) begin
            BTN_START = 1'b1;
            start_at[cyc + LAT + 1] = 1'b1;
        end
        if (do_clear) begin
            BTN_CLEAR = 1'b1;
            clear_at[cyc + LAT + 1] = 1'b1;
        end
        step(hold);
        BTN_START = 1'b0;
        BTN_CLEAR = 1'b0;
        step(gap);
    endtask

    task automatic do_reset(int n);
        RST_N = 1'b0;
        step(n);
        check("rst_low", 32'(CNTVAL_low), 32'd0);
        check("rst_high", 32'(CNTVAL_high), 32'd0);
        check("rst_ov", 32'(OV), 32'd0);
        check("rst_running", 32'(RUNNING), 32'd0);
        check("rst_seg", 32'(SEG), 32'h40);
        check("rst_dig_sel", 32'(DIG_SEL), 32'd2);
        RST_N = 1'b1;
    endtask

    task automatic wait_run_phase(int val, int modulus, int budget);
        int n = 0;
        while (!(m_mode == M_RUN && (m_run % modulus) == val) && n < budget) begin
            step(1);
            n++;
        end
        if (n >= budget) check("wait_timeout", 32'(n), 32'(budget));
    endtask

    initial begin
        step(1);
        do_reset(2);
        step(2);

        // Start: increments 1,2,3 at TICK_DIV spacing; release must not pause.
        press(1'b1, 1'b0, 10, 6);
        step(12);

        // Run through 98 -> 99 -> 00 with the OV pulse.
        wait_run_phase(392, 400, 600);
        step(12);

        // Pause with the prescaler at 2, then resume.
        wait_run_phase(pmod(2 - LAT - 1, TICK_DIV), TICK_DIV, 20);
        press(1'b1, 1'b0, DB_CYCLES + 2, DB_CYCLES + 2);
        step(10);
        press(1'b1, 1'b0, DB_CYCLES + 2, DB_CYCLES + 2);
        step(6);

        // Simultaneous start and clear while showing 37.
        wait_run_phase(pmod(149 - LAT, 400), 400, 500);
        press(1'b1, 1'b1, DB_CYCLES + 2, DB_CYCLES + 2);
        check("clear_running", 32'(RUNNING), 32'd0);
        check("clear_digits", {24'd0, CNTVAL_high, CNTVAL_low}, 32'd0);

`ifdef STOPWATCH_DEBOUNCE_EN
        // Short glitches are swallowed; a long hold gives one pulse.
        repeat (2) begin
            BTN_START = 1'b1;
            step(3);
            BTN_START = 1'b0;
            step(3);
        end
        step(10);
        check("glitch_running", 32'(RUNNING), 32'd0);
        press(1'b1, 1'b0, DB_CYCLES + 2, DB_CYCLES + 4);
        check("debounced_start", 32'(RUNNING), 32'd1);
`endif

        for (int i = 0; i < 30; i++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 5)
                press(1'b1, 1'b0, $urandom_range(DB_CYCLES + 1, DB_CYCLES + 6), $urandom_range(DB_CYCLES + 1, DB_CYCLES + 6));
            else if (op <= 7)
                press(1'b0, 1'b1, $urandom_range(DB_CYCLES + 1, DB_CYCLES + 6), $urandom_range(DB_CYCLES + 1, DB_CYCLES + 6));
            else if (op == 8)
                press(1'b1, 1'b1, $urandom_range(DB_CYCLES + 1, DB_CYCLES + 6), $urandom_range(DB_CYCLES + 1, DB_CYCLES + 6));
            else
                do_reset($urandom_range(1, 3));
            step($urandom_range(0, 40));
        end

        step(20);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        failures++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Two-digit (00–99) stopwatch controller wrapping the decimal counter/7-segment path. Turns start/pause and clear push-buttons into a run/pause/idle state machine and generates the count-enable tick from the system clock. Owns the BCD low/high digit counters with carry and wrap. Time-multiplexes both digits onto one shared 7-segment bus with digit select.

## Interface
- TICK_DIV, 5000000: CLK cycles per count tick (≥2)
- SCAN_DIV, 50000: CLK cycles per display digit slot (≥2)
- DB_CYCLES, 250000: stable-input cycles required by debounce (≥1)
- CLK  in  1  system clock; all logic on rising edge
- RST_N  in  1  reset, synchronous, active-low
- BTN_START  in  1  start/pause button, active-high, asynchronous
- BTN_CLEAR  in  1  clear button, active-high, asynchronous
- CNTVAL_low  out  4  BCD units digit
- CNTVAL_high  out  4  BCD tens digit
- OV  out  1  one-cycle pulse on 99→00 wrap
- SEG  out  7  segments gfedcba, active-low, shared bus
- DIG_SEL  out  2  digit enables, active-low; bit0 = units, bit1 = tens
- RUNNING  out  1  high in RUN state

## Operation
- Both buttons pass a 2-FF synchronizer, then the debouncer, then a rising-edge detector. Result: one-cycle pulses start_p and clear_p.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE: start_p → RUN.
  - RUN: start_p → PAUSE.
  - PAUSE: start_p → RUN.
  - clear_p from any state → IDLE. It also zeroes both digits and the prescaler.
  - clear_p wins over a simultaneous start_p.
- Prescaler counts 0..TICK_DIV-1, and only in RUN.
  - In PAUSE it holds its value, so resume keeps the partial tick.
  - tick is asserted when prescaler == TICK_DIV-1; the prescaler wraps to 0 on that edge.
- Counter update on tick:
  - CNTVAL_low == 9 → low = 0, and high increments.
  - Otherwise low increments.
  - CNTVAL_high == 9 with carry → high = 0, and OV = 1 for that one cycle.
- Digits never leave 0..9.
- Display scan counter runs in every state.
  - Counts 0..SCAN_DIV-1; on wrap the active digit toggles.
  - Units slot: DIG_SEL = 2'b10 and SEG = decode(CNTVAL_low).
  - Tens slot: DIG_SEL = 2'b01 and SEG = decode(CNTVAL_high).
- Decode table (gfedcba, active-low):
  - 0: 1000000; 1: 1111001; 2: 0100100; 3: 0110000; 4: 0011001
  - 5: 0010010; 6: 0000010; 7: 1111000; 8: 0000000; 9: 0010000
  - Anything else: 1111111.

## Timing
- Reset values (RST_N low at an edge):
  - FSM IDLE; CNTVAL_low = 0, CNTVAL_high = 0, OV = 0, RUNNING = 0.
  - Prescaler and scan counter 0.
  - DIG_SEL = 2'b10, SEG = 1000000.
  - Synchronizer and debounce state 0.
- Reset mid-run has the same effect; no pulse survives reset.
- Button latency: a level change on a BTN pin produces start_p/clear_p N cycles later.
  - Without the debounce macro: N = 3.
  - With it: N = 3 + DB_CYCLES.
  - The FSM or counters change on the edge after the pulse.
- From IDLE, the first increment lands TICK_DIV cycles after the edge on which RUNNING rises.
- OV rises on the same edge that the digits become 00, and falls on the next edge.
- SEG and DIG_SEL are registered together and change on the same edge, so there is no cross-digit glitch.
- SEG reflects a counter change within one cycle when its digit is active.
- A button held down produces exactly one pulse; release produces none.

## Configuration
- STOPWATCH_DEBOUNCE_EN defined:
  - The debounced level changes only after the synchronized input has been stable and different for DB_CYCLES consecutive cycles.
  - Shorter bounces are ignored.
- Not defined:
  - The debouncer is removed, and the edge detector takes the synchronized level directly.
  - DB_CYCLES is unused.

## Structure
- Shared package `stopwatch_pkg` holds:
  - the FSM state enum (IDLE/RUN/PAUSE);
  - the 7-segment decode constants for 0–9 and blank;
  - the DIG_SEL constants for the units and tens slots.
- Sub-module `seg7_decode`: combinational 4-bit BCD → 7-bit active-low segments, instantiated once after the digit mux.
- Debounce is written as a per-button generate block, not a separate module.

## Test plan
All scenarios use TICK_DIV=4, SCAN_DIV=3, DB_CYCLES=4.
- Reset, then hold RST_N low for 2 cycles → all outputs at reset values; SEG=1000000, DIG_SEL=2'b10.
- Press START for 10 cycles → RUNNING rises once; CNTVAL_low reads 1,2,3 at 4-cycle intervals; release produces no extra pulse.
- Run to 98 → 99 → 00 → CNTVAL_high/low cycle 9/8 → 9/9 → 0/0; OV high exactly one cycle on the 00 edge.
- START again in RUN at prescaler=2, then START to resume → digits frozen while in PAUSE; the next increment comes 2 cycles after RUNNING re-rises.
- START and CLEAR pressed the same cycle while RUN at 37 → IDLE, digits 00, RUNNING 0.
- Macro defined, START toggled with 3-cycle glitches → no pulse; hold 4+ cycles → one pulse at +7 cycles.
